// File: rtl/seq_subtractor_if.sv
// Start/busy/done handshake and operand/result bus for seq_subtractor.
//   start, in0, in1, bin : request and operands (controller -> subtractor)
//   busy, done           : operation in progress / one-cycle result-valid pulse
//   diff, bout           : registered result and borrow-out
//   ovf                  : signed overflow flag, only when SEQ_SUB_OVF_EN is defined
// Modports: master = datapath controller, slave = subtractor.
interface seq_subtractor_if #(
  parameter int unsigned WIDTH = 16
);
  logic             start;
  logic [WIDTH-1:0] in0;
  logic [WIDTH-1:0] in1;
  logic             bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             bout;
`ifdef SEQ_SUB_OVF_EN
  logic             ovf;

  modport master (
    output start, in0, in1, bin,
    input  busy, done, diff, bout, ovf
  );
  modport slave (
    input  start, in0, in1, bin,
    output busy, done, diff, bout, ovf
  );
`else
  modport master (
    output start, in0, in1, bin,
    input  busy, done, diff, bout
  );
  modport slave (
    input  start, in0, in1, bin,
    output busy, done, diff, bout
  );
`endif
endinterface

// File: rtl/seq_subtractor.sv
// Multi-cycle subtractor: diff = in0 - in1 - bin over WIDTH bits, CHUNK bits per clock,
// with the borrow carried between chunks in a register. N = WIDTH/CHUNK clocks per result.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_subtractor_if slave modport (start/in0/in1/bin in; busy/done/diff/bout out)
// Optional feature macro: SEQ_SUB_OVF_EN adds the registered signed overflow flag bus.ovf.
// WIDTH must be an integer multiple of CHUNK.
module seq_subtractor #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input logic              clk,
  input logic              rst_n,
  seq_subtractor_if.slave  bus
);

  localparam int unsigned N    = WIDTH / CHUNK;
  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [0:0] {StIdle, StRun} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]  a_q, a_d;
  logic [WIDTH-1:0]  b_q, b_d;
  logic              borrow_q, borrow_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic              bout_q, bout_d;
  logic              done_q, done_d;
`ifdef SEQ_SUB_OVF_EN
  logic              ovf_q, ovf_d;
`endif

  logic [31:0]       idx;
  logic [CHUNK-1:0]  a_chunk;
  logic [CHUNK-1:0]  b_chunk;
  logic [CHUNK:0]    chunk_res;
  logic              last;

  // Bit offset of the chunk handled this cycle.
  assign idx     = 32'(cnt_q) * CHUNK;
  assign a_chunk = a_q[idx +: CHUNK];
  assign b_chunk = b_q[idx +: CHUNK];
  // CHUNK+1 bits wide so the top bit is the borrow out of this chunk.
  assign chunk_res = {1'b0, a_chunk} - {1'b0, b_chunk} - {{CHUNK{1'b0}}, borrow_q};
  assign last      = (cnt_q == CntW'(N - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    borrow_d = borrow_q;
    diff_d   = diff_q;
    bout_d   = bout_q;
    done_d   = 1'b0;
`ifdef SEQ_SUB_OVF_EN
    ovf_d    = ovf_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          a_d      = bus.in0;
          b_d      = bus.in1;
          borrow_d = bus.bin;
          cnt_d    = '0;
          state_d  = StRun;
        end
      end
      StRun: begin
        // diff is overwritten chunk by chunk; untouched chunks keep the old result.
        diff_d[idx +: CHUNK] = chunk_res[CHUNK-1:0];
        borrow_d             = chunk_res[CHUNK];
        cnt_d                = cnt_q + 1'b1;
        if (last) begin
          bout_d  = chunk_res[CHUNK];
          done_d  = 1'b1;
          cnt_d   = '0;
          state_d = StIdle;
`ifdef SEQ_SUB_OVF_EN
          // Operand signs differ and the result sign differs from the minuend.
          ovf_d = (a_q[WIDTH-1] ^ b_q[WIDTH-1]) & (a_q[WIDTH-1] ^ chunk_res[CHUNK-1]);
`endif
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      borrow_q <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef SEQ_SUB_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      borrow_q <= borrow_d;
      diff_q   <= diff_d;
      bout_q   <= bout_d;
      done_q   <= done_d;
`ifdef SEQ_SUB_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign bus.busy = (state_q == StRun);
  assign bus.done = done_q;
  assign bus.diff = diff_q;
  assign bus.bout = bout_q;
`ifdef SEQ_SUB_OVF_EN
  assign bus.ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_seq_subtractor.sv
// Directed bench for seq_subtractor. Three instances (CHUNK = 4, 1, 16; WIDTH = 16) share
// the same request and operand inputs; the CHUNK = 4 instance carries the detailed
// handshake checks, and every operation is compared across all three.
module tb_seq_subtractor;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [15:0] in0;
  logic [15:0] in1;
  logic        bin;

  int tests_run;
  int tests_failed;

  // Per-instance results captured by do_op: index 0 = CHUNK 4, 1 = CHUNK 1, 2 = CHUNK 16.
  logic [15:0] r_diff [3];
  logic        r_bout [3];
  logic        r_ovf  [3];
  int          r_lat  [3];
  // Negedges from request to visible done: N + 1.
  int          exp_lat [3];

  seq_subtractor_if #(.WIDTH(16)) if4  ();
  seq_subtractor_if #(.WIDTH(16)) if1  ();
  seq_subtractor_if #(.WIDTH(16)) if16 ();

  assign if4.start  = start;
  assign if4.in0    = in0;
  assign if4.in1    = in1;
  assign if4.bin    = bin;
  assign if1.start  = start;
  assign if1.in0    = in0;
  assign if1.in1    = in1;
  assign if1.bin    = bin;
  assign if16.start = start;
  assign if16.in0   = in0;
  assign if16.in1   = in1;
  assign if16.bin   = bin;

  seq_subtractor #(.WIDTH(16), .CHUNK(4))  u_dut4  (.clk(clk), .rst_n(rst_n), .bus(if4));
  seq_subtractor #(.WIDTH(16), .CHUNK(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(if1));
  seq_subtractor #(.WIDTH(16), .CHUNK(16)) u_dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Issues one request and records when each instance pulses done (bounded wait).
  task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic c);
    logic [2:0] seen;
    seen = '0;
    for (int i = 0; i < 3; i++) begin
      r_lat[i] = -1;
      r_diff[i] = 'x;
      r_bout[i] = 1'bx;
      r_ovf[i] = 1'bx;
    end
    @(negedge clk);
    in0 = a; in1 = b; bin = c; start = 1'b1;
    for (int t = 1; t <= 40 && seen != 3'b111; t++) begin
      @(negedge clk);
      if (t == 1) start = 1'b0;
      if (!seen[0] && if4.done) begin
        seen[0] = 1'b1; r_lat[0] = t; r_diff[0] = if4.diff; r_bout[0] = if4.bout;
`ifdef SEQ_SUB_OVF_EN
        r_ovf[0] = if4.ovf;
`endif
      end
      if (!seen[1] && if1.done) begin
        seen[1] = 1'b1; r_lat[1] = t; r_diff[1] = if1.diff; r_bout[1] = if1.bout;
`ifdef SEQ_SUB_OVF_EN
        r_ovf[1] = if1.ovf;
`endif
      end
      if (!seen[2] && if16.done) begin
        seen[2] = 1'b1; r_lat[2] = t; r_diff[2] = if16.diff; r_bout[2] = if16.bout;
`ifdef SEQ_SUB_OVF_EN
        r_ovf[2] = if16.ovf;
`endif
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; in0 = '0; in1 = '0; bin = 1'b0;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({if4.busy, if4.done, if4.diff, if4.bout} !== 19'd0) begin
      tests_failed++;
      $display("FAIL reset_outputs: busy/done/diff/bout = %b/%b/%h/%b, required 0/0/0000/0",
               if4.busy, if4.done, if4.diff, if4.bout);
    end
    tests_run++;
    if ({if1.busy, if1.done, if16.busy, if16.done} !== 4'd0) begin
      tests_failed++;
      $display("FAIL reset_other: busy1/done1/busy16/done16 = %b%b%b%b, required 0000",
               if1.busy, if1.done, if16.busy, if16.done);
    end
`ifdef SEQ_SUB_OVF_EN
    tests_run++;
    if (if4.ovf !== 1'b0) begin
      tests_failed++;
      $display("FAIL reset_ovf: got %b, required 0", if4.ovf);
    end
`endif
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // 0x1234 - 0x0234: busy for exactly four cycles, one done pulse, result held.
  task automatic test_basic();
    int busy_bad;
    busy_bad = 0;
    in0 = 16'h1234; in1 = 16'h0234; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (c > 0) @(negedge clk);
      if (if4.busy !== 1'b1 || if4.done !== 1'b0) busy_bad++;
    end
    tests_run++;
    if (busy_bad != 0) begin
      tests_failed++;
      $display("FAIL basic_busy: %0d of 4 run cycles had busy!=1 or done!=0, required 0",
               busy_bad);
    end
    @(negedge clk);
    tests_run++;
    if ({if4.done, if4.busy} !== 2'b10) begin
      tests_failed++;
      $display("FAIL basic_done: done/busy = %b/%b, required 1/0", if4.done, if4.busy);
    end
    tests_run++;
    if ({if4.diff, if4.bout} !== {16'h1000, 1'b0}) begin
      tests_failed++;
      $display("FAIL basic_result: diff/bout = %h/%b, required 1000/0", if4.diff, if4.bout);
    end
    @(negedge clk);
    tests_run++;
    if ({if4.done, if4.diff} !== {1'b0, 16'h1000}) begin
      tests_failed++;
      $display("FAIL basic_hold: done/diff = %b/%h, required 0/1000", if4.done, if4.diff);
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_borrow_ripple();
    do_op(16'h0000, 16'h0001, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({r_diff[i], r_bout[i]} !== {16'hFFFF, 1'b1} || r_lat[i] != exp_lat[i]) begin
        tests_failed++;
        $display("FAIL ripple[%0d]: diff/bout/lat = %h/%b/%0d, required ffff/1/%0d",
                 i, r_diff[i], r_bout[i], r_lat[i], exp_lat[i]);
      end
    end
  endtask

  task automatic test_borrow_in();
    do_op(16'h0005, 16'h0003, 1'b1);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({r_diff[i], r_bout[i]} !== {16'h0001, 1'b0} || r_lat[i] != exp_lat[i]) begin
        tests_failed++;
        $display("FAIL bin[%0d]: diff/bout/lat = %h/%b/%0d, required 0001/0/%0d",
                 i, r_diff[i], r_bout[i], r_lat[i], exp_lat[i]);
      end
    end
  endtask

`ifdef SEQ_SUB_OVF_EN
  task automatic test_ovf();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic [15:0] ed [3];
    logic        eb [3];
    logic        eo [3];
    va = '{16'h8000, 16'h7FFF, 16'h1234};
    vb = '{16'h0001, 16'hFFFF, 16'h0234};
    ed = '{16'h7FFF, 16'h8000, 16'h1000};
    eb = '{1'b0, 1'b1, 1'b0};
    eo = '{1'b1, 1'b1, 1'b0};
    for (int v = 0; v < 3; v++) begin
      do_op(va[v], vb[v], 1'b0);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if ({r_diff[i], r_bout[i], r_ovf[i]} !== {ed[v], eb[v], eo[v]}) begin
          tests_failed++;
          $display("FAIL ovf[%0d][%0d]: diff/bout/ovf = %h/%b/%b, required %h/%b/%b",
                   v, i, r_diff[i], r_bout[i], r_ovf[i], ed[v], eb[v], eo[v]);
        end
      end
    end
  endtask
`endif

  // start held high; operands and start toggle junk while busy; done every 5 cycles.
  task automatic test_back_to_back();
    logic [15:0] va [3];
    logic [15:0] vb [3];
    logic        vc [3];
    logic [15:0] ed [3];
    logic        eb [3];
    int          cnt;
    va = '{16'hABCD, 16'hFFFF, 16'h0100};
    vb = '{16'hABCD, 16'h0001, 16'h0200};
    vc = '{1'b0, 1'b0, 1'b1};
    ed = '{16'h0000, 16'hFFFE, 16'hFEFF};
    eb = '{1'b0, 1'b0, 1'b1};
    @(negedge clk);
    in0 = va[0]; in1 = vb[0]; bin = vc[0]; start = 1'b1;
    for (int j = 0; j < 3; j++) begin
      @(negedge clk);
      cnt = 1;
      in0 = 16'h5555; in1 = 16'hAAAA; bin = 1'b1;
      while (!if4.done && cnt < 20) begin
        @(negedge clk);
        cnt++;
        start = (cnt != 3);
      end
      start = 1'b1;
      tests_run++;
      if (cnt != 5 || {if4.diff, if4.bout} !== {ed[j], eb[j]}) begin
        tests_failed++;
        $display("FAIL b2b[%0d]: cycles/diff/bout = %0d/%h/%b, required 5/%h/%b",
                 j, cnt, if4.diff, if4.bout, ed[j], eb[j]);
      end
      if (j < 2) begin
        in0 = va[j+1]; in1 = vb[j+1]; bin = vc[j+1];
      end else begin
        start = 1'b0;
      end
    end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int saw_done;
    saw_done = 0;
    in0 = 16'h0000; in1 = 16'h0003; bin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    // Only chunk 0 written so far over the previous 0xFEFF result.
    tests_run++;
    if ({if4.busy, if4.diff} !== {1'b1, 16'hFEFD}) begin
      tests_failed++;
      $display("FAIL mid_partial: busy/diff = %b/%h, required 1/fefd", if4.busy, if4.diff);
    end
    rst_n = 1'b0;
    #1;
    tests_run++;
    if ({if4.busy, if4.done, if4.diff, if4.bout} !== 19'd0) begin
      tests_failed++;
      $display("FAIL mid_reset: busy/done/diff/bout = %b/%b/%h/%b, required 0/0/0000/0",
               if4.busy, if4.done, if4.diff, if4.bout);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (if4.done || if4.busy) saw_done++;
    end
    tests_run++;
    if (saw_done != 0) begin
      tests_failed++;
      $display("FAIL mid_no_done: %0d cycles with done/busy after abort, required 0", saw_done);
    end
    do_op(16'h1234, 16'h0234, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tests_run++;
      if ({r_diff[i], r_bout[i]} !== {16'h1000, 1'b0} || r_lat[i] != exp_lat[i]) begin
        tests_failed++;
        $display("FAIL mid_restart[%0d]: diff/bout/lat = %h/%b/%0d, required 1000/0/%0d",
                 i, r_diff[i], r_bout[i], r_lat[i], exp_lat[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [16:0] full;
    for (int k = 0; k < 6; k++) begin
      a = 16'($urandom);
      b = 16'($urandom);
      c = 1'($urandom);
      full = {1'b0, a} - {1'b0, b} - {16'd0, c};
      do_op(a, b, c);
      for (int i = 0; i < 3; i++) begin
        tests_run++;
        if ({r_diff[i], r_bout[i]} !== {full[15:0], full[16]} || r_lat[i] != exp_lat[i]) begin
          tests_failed++;
          $display("FAIL rand[%0d][%0d] %h-%h-%b: diff/bout/lat = %h/%b/%0d, required %h/%b/%0d",
                   k, i, a, b, c, r_diff[i], r_bout[i], r_lat[i], full[15:0], full[16],
                   exp_lat[i]);
        end
      end
    end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    exp_lat = '{5, 17, 2};
    test_reset();
    test_basic();
    test_borrow_ripple();
    test_borrow_in();
`ifdef SEQ_SUB_OVF_EN
    test_ovf();
`endif
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
